// File: rtl/oldest_issue_selector_pkg.sv
// Shared core parameters for the issue-select logic.
// The age-tag width follows the ROB tag width so selector and ROB always agree.
package oldest_issue_selector_pkg;

    localparam int ROB_TAG_W  = 8;
    localparam int DEF_ENTNUM = 8;
    localparam int DEF_VALLEN = ROB_TAG_W;

endpackage

// File: rtl/oldest_issue_selector_age_compare_node.sv
// One node of the oldest-first selection tree.
// The a side always carries the lower entry indices, so equal ages resolve to a.
module age_compare_node #(
    parameter int ENTLEN = 3,
    parameter int VALLEN = 8
) (
    input  logic              a_req,
    input  logic [ENTLEN-1:0] a_entry,
    input  logic [VALLEN-1:0] a_rel,
    input  logic              b_req,
    input  logic [ENTLEN-1:0] b_entry,
    input  logic [VALLEN-1:0] b_rel,
    output logic              out_req,
    output logic [ENTLEN-1:0] out_entry,
    output logic [VALLEN-1:0] out_rel
);

    logic take_b;

    // b wins only when it is strictly older, or a is not requesting at all
    assign take_b    = b_req && (!a_req || (b_rel < a_rel));
    assign out_req   = a_req || b_req;
    assign out_entry = take_b ? b_entry : a_entry;
    assign out_rel   = take_b ? b_rel : a_rel;

endmodule

// File: rtl/oldest_issue_selector.sv
// Picks the oldest requesting entry (age relative to the ROB head) and holds it
// in a valid/ready output register until the consumer takes it.
module oldest_issue_selector
    import oldest_issue_selector_pkg::*;
#(
    parameter int ENTNUM = DEF_ENTNUM,
    parameter int ENTLEN = $clog2(ENTNUM),
    parameter int VALLEN = DEF_VALLEN
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     flush_i,
    input  logic [ENTNUM-1:0]        req_vector_i,
    input  logic [ENTNUM*VALLEN-1:0] value_vector_i,
    input  logic [VALLEN-1:0]        head_tag_i,
    input  logic                     grant_ready_i,
    output logic                     grant_valid_o,
    output logic [ENTLEN-1:0]        grant_entry_o,
    output logic [VALLEN-1:0]        grant_value_o
);

    localparam int LEVELS = $clog2(ENTNUM);

    logic [ENTNUM-1:0] held_mask;
    logic [ENTNUM-1:0] cand_req;
    logic              sel_req;
    logic [ENTLEN-1:0] sel_entry;
    logic [VALLEN-1:0] sel_rel;
    logic              load;

    // The held entry is masked whenever the register is full; that only matters
    // on the accept cycle, so the same entry is never granted back-to-back.
    assign held_mask = grant_valid_o ? (ENTNUM'(1) << grant_entry_o) : '0;
    assign cand_req  = req_vector_i & ~held_mask;

    genvar l, n;
    generate
        for (l = 0; l <= LEVELS; l++) begin : lvl
            localparam int W = ENTNUM >> l;
            logic              req [W];
            logic [ENTLEN-1:0] ent [W];
            logic [VALLEN-1:0] rel [W];

            if (l == 0) begin : leaf
                // Modular subtraction keeps ordering correct across tag wrap.
                for (n = 0; n < W; n++) begin : in
                    assign req[n] = cand_req[n];
                    assign ent[n] = ENTLEN'(n);
                    assign rel[n] = value_vector_i[n*VALLEN +: VALLEN] - head_tag_i;
                end
            end else begin : node
                for (n = 0; n < W; n++) begin : cmp
                    age_compare_node #(
                        .ENTLEN(ENTLEN),
                        .VALLEN(VALLEN)
                    ) u_node (
                        .a_req    (lvl[l-1].req[2*n]),
                        .a_entry  (lvl[l-1].ent[2*n]),
                        .a_rel    (lvl[l-1].rel[2*n]),
                        .b_req    (lvl[l-1].req[2*n+1]),
                        .b_entry  (lvl[l-1].ent[2*n+1]),
                        .b_rel    (lvl[l-1].rel[2*n+1]),
                        .out_req  (req[n]),
                        .out_entry(ent[n]),
                        .out_rel  (rel[n])
                    );
                end
            end
        end
    endgenerate

    assign sel_req   = lvl[LEVELS].req[0];
    assign sel_entry = lvl[LEVELS].ent[0];
    assign sel_rel   = lvl[LEVELS].rel[0];
    assign load      = !grant_valid_o || grant_ready_i;

    // Priority: reset, flush, load, squash of a pending grant, hold.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            grant_valid_o <= 1'b0;
            grant_entry_o <= '0;
            grant_value_o <= '0;
        end else if (flush_i) begin
            grant_valid_o <= 1'b0;
        end else if (load) begin
            grant_valid_o <= sel_req;
            if (sel_req) begin
                grant_entry_o <= sel_entry;
                grant_value_o <= sel_rel + head_tag_i;
            end
        end else if (!req_vector_i[grant_entry_o]) begin
            grant_valid_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_oldest_issue_selector.sv
// Directed vector table for the listed scenarios, then randomized traffic
// checked against an age-ordering reference model.
module tb_oldest_issue_selector;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic [7:0]  req;
    logic [63:0] vals;
    logic [7:0]  head;
    logic        ready;
    logic        g_valid;
    logic [2:0]  g_entry;
    logic [7:0]  g_value;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    oldest_issue_selector dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .flush_i       (flush),
        .req_vector_i  (req),
        .value_vector_i(vals),
        .head_tag_i    (head),
        .grant_ready_i (ready),
        .grant_valid_o (g_valid),
        .grant_entry_o (g_entry),
        .grant_value_o (g_value)
    );

    typedef struct {
        string       name;
        logic        rst;
        logic        flush;
        logic        ready;
        logic [7:0]  req;
        logic [7:0]  head;
        logic [63:0] vals;
        logic        exp_valid;
        logic [2:0]  exp_entry;
        logic [7:0]  exp_value;
    } vec_t;

    vec_t tbl[$];

    // Reference model state: what the output register should hold.
    logic       m_valid;
    logic [2:0] m_entry;
    logic [7:0] m_value;

    function automatic logic [63:0] mkv(input int t0, t1, t2, t3, t4, t5, t6, t7);
        int t[8];
        logic [63:0] r;
        t = '{t0, t1, t2, t3, t4, t5, t6, t7};
        for (int k = 0; k < 8; k++) r[k*8 +: 8] = t[k][7:0];
        return r;
    endfunction

    function automatic vec_t row(input string nm, input logic r, f, rdy, input logic [7:0] rq,
                                 input logic [7:0] hd, input logic [63:0] v,
                                 input logic ev, input logic [2:0] ee, input logic [7:0] evl);
        vec_t x;
        x.name = nm; x.rst = r; x.flush = f; x.ready = rdy; x.req = rq; x.head = hd; x.vals = v;
        x.exp_valid = ev; x.exp_entry = ee; x.exp_value = evl;
        return x;
    endfunction

    task automatic check(input string nm, input logic ev, input logic [2:0] ee, input logic [7:0] evl);
        checks++;
        if (g_valid !== ev || g_entry !== ee || g_value !== evl) begin
            errors++;
            $display("FAIL %s: got valid=%0d entry=%0d value=%0d, want valid=%0d entry=%0d value=%0d",
                     nm, g_valid, g_entry, g_value, ev, ee, evl);
        end
    endtask

    // Next register contents from the selection rules, using plain integer ages.
    task automatic model_step();
        int best, best_age, age;
        if (rst) begin
            m_valid = 1'b0; m_entry = 3'd0; m_value = 8'd0;
        end else if (flush) begin
            m_valid = 1'b0;
        end else if (!m_valid || ready) begin
            best = -1;
            best_age = 1000;
            for (int k = 0; k < 8; k++) begin
                if (req[k] && !(m_valid && k == int'(m_entry))) begin
                    age = (int'(vals[k*8 +: 8]) - int'(head) + 256) % 256;
                    if (age < best_age) begin
                        best_age = age;
                        best = k;
                    end
                end
            end
            if (best >= 0) begin
                m_valid = 1'b1;
                m_entry = best[2:0];
                m_value = vals[best*8 +: 8];
            end else begin
                m_valid = 1'b0;
            end
        end else if (!req[m_entry]) begin
            m_valid = 1'b0;
        end
    endtask

    logic [63:0] va, vb, vc, vd, ve;

    initial begin
        rst = 1'b1; flush = 1'b0; req = '0; vals = '0; head = '0; ready = 1'b0;

        va = mkv(0, 5, 3, 0, 0, 9, 0, 0);
        vb = mkv(2, 0, 0, 252, 0, 0, 0, 0);
        vc = mkv(0, 10, 0, 0, 20, 0, 0, 0);
        vd = mkv(0, 0, 7, 0, 0, 0, 7, 0);
        ve = mkv(0, 10, 0, 0, 0, 30, 0, 0);

        tbl.push_back(row("reset",          1, 0, 0, 8'h00,       0,   va, 0, 0, 0));
        tbl.push_back(row("basic_grant",    0, 0, 0, 8'b0010_0110, 0,   va, 1, 2, 3));
        tbl.push_back(row("basic_hold",     0, 0, 0, 8'b0010_0110, 0,   va, 1, 2, 3));
        tbl.push_back(row("basic_next",     0, 0, 1, 8'b0010_0110, 0,   va, 1, 1, 5));
        tbl.push_back(row("basic_empty",    0, 0, 1, 8'h00,       0,   va, 0, 1, 5));
        tbl.push_back(row("wrap",           0, 0, 1, 8'b0000_1001, 250, vb, 1, 3, 252));
        tbl.push_back(row("wrap_empty",     0, 0, 1, 8'h00,       250, vb, 0, 3, 252));
        tbl.push_back(row("bp_load",        0, 0, 1, 8'b0001_0000, 0,   vc, 1, 4, 20));
        tbl.push_back(row("bp_stall1",      0, 0, 0, 8'b0001_0010, 0,   vc, 1, 4, 20));
        tbl.push_back(row("bp_stall2",      0, 0, 0, 8'b0001_0010, 0,   vc, 1, 4, 20));
        tbl.push_back(row("bp_stall3",      0, 0, 0, 8'b0001_0010, 0,   vc, 1, 4, 20));
        tbl.push_back(row("bp_release",     0, 0, 1, 8'b0001_0010, 0,   vc, 1, 1, 10));
        tbl.push_back(row("bp_empty",       0, 0, 1, 8'h00,       0,   vc, 0, 1, 10));
        tbl.push_back(row("tie_low",        0, 0, 1, 8'b0100_0100, 0,   vd, 1, 2, 7));
        tbl.push_back(row("tie_next",       0, 0, 1, 8'b0100_0100, 0,   vd, 1, 6, 7));
        tbl.push_back(row("tie_empty",      0, 0, 1, 8'h00,       0,   vd, 0, 6, 7));
        tbl.push_back(row("squash_load",    0, 0, 0, 8'b0010_0000, 0,   ve, 1, 5, 30));
        tbl.push_back(row("squash_drop",    0, 0, 0, 8'h00,       0,   ve, 0, 5, 30));
        tbl.push_back(row("squash_reload",  0, 0, 0, 8'b0010_0000, 0,   ve, 1, 5, 30));
        tbl.push_back(row("flush",          0, 1, 1, 8'b0010_0010, 0,   ve, 0, 5, 30));
        tbl.push_back(row("after_flush",    0, 0, 0, 8'b0010_0010, 0,   ve, 1, 1, 10));
        tbl.push_back(row("rst_mid",        1, 0, 0, 8'b0010_0010, 0,   ve, 0, 0, 0));
        tbl.push_back(row("rst_release",    0, 0, 0, 8'b0000_0010, 0,   ve, 1, 1, 10));
        tbl.push_back(row("rst_over_flush", 1, 1, 1, 8'b0000_0010, 0,   ve, 0, 0, 0));

        foreach (tbl[i]) begin
            rst = tbl[i].rst; flush = tbl[i].flush; ready = tbl[i].ready;
            req = tbl[i].req; head = tbl[i].head; vals = tbl[i].vals;
            @(posedge clk);
            #1;
            check(tbl[i].name, tbl[i].exp_valid, tbl[i].exp_entry, tbl[i].exp_value);
        end

        // Last table row left the register in reset state.
        m_valid = 1'b0; m_entry = 3'd0; m_value = 8'd0;

        for (int c = 0; c < 3000; c++) begin
            rst   = ($urandom_range(0, 99) == 0);
            flush = ($urandom_range(0, 19) == 0);
            ready = ($urandom_range(0, 3) != 0);
            head  = 8'($urandom_range(0, 255));
            req   = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 3) == 0) req = req & 8'($urandom_range(0, 255));
            for (int k = 0; k < 8; k++) begin
                if ($urandom_range(0, 1) == 0)
                    vals[k*8 +: 8] = head + 8'($urandom_range(0, 6));
                else
                    vals[k*8 +: 8] = 8'($urandom_range(0, 255));
            end
            model_step();
            @(posedge clk);
            #1;
            check("random", m_valid, m_entry, m_value);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
